// File: rtl/mda_motor_control_ramp_ctrl_if.sv
// mda_motor_control_ramp_ctrl_if: command handshake and PWM-generator bus of the ramp controller.
// wdt_tripped exists only when MDA_MOTOR_CONTROL_WATCHDOG_EN is defined.
interface mda_motor_control_ramp_ctrl_if #(
    parameter int unsigned PERIOD_LENGTH = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_dir;
    logic [PERIOD_LENGTH-1:0] cmd_duty;
    logic                     cmd_enable;
    logic [PERIOD_LENGTH-1:0] period;
    logic                     pwm_dir;
    logic                     pwm_on;
    logic [PERIOD_LENGTH-1:0] pwm_duty;
    logic                     busy;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
    logic                     wdt_tripped;
    modport master (output cmd_valid, cmd_dir, cmd_duty, cmd_enable, period,
                    input cmd_ready, pwm_dir, pwm_on, pwm_duty, busy, wdt_tripped);
    modport slave  (input cmd_valid, cmd_dir, cmd_duty, cmd_enable, period,
                    output cmd_ready, pwm_dir, pwm_on, pwm_duty, busy, wdt_tripped);
`else
    modport master (output cmd_valid, cmd_dir, cmd_duty, cmd_enable, period,
                    input cmd_ready, pwm_dir, pwm_on, pwm_duty, busy);
    modport slave  (input cmd_valid, cmd_dir, cmd_duty, cmd_enable, period,
                    output cmd_ready, pwm_dir, pwm_on, pwm_duty, busy);
`endif
endinterface

// File: rtl/mda_motor_control_ramp_ctrl.sv
// mda_motor_control_ramp_ctrl: slews H-bridge PWM duty toward commanded target with braking and dead-time on reversal.
// Optional command watchdog enabled by MDA_MOTOR_CONTROL_WATCHDOG_EN.
module mda_motor_control_ramp_ctrl #(
    parameter int unsigned PERIOD_LENGTH   = 16,
    parameter int unsigned RAMP_STEP       = 16,
    parameter int unsigned RAMP_DIV        = 1000,
    parameter int unsigned DEADTIME_CYCLES = 500,
    parameter int unsigned WDT_TIMEOUT     = 5000000
) (
    input logic clk,
    input logic reset,
    mda_motor_control_ramp_ctrl_if.slave bus
);
    localparam int W  = PERIOD_LENGTH;
    localparam int PW = $clog2(RAMP_DIV + 1);
    localparam int DW = $clog2(DEADTIME_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEADTIME} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   duty_q, duty_d, tduty_q, tduty_d, eff, goal, step;
    logic [W:0]     up;
    logic           dir_q, dir_d, on_q, on_d, rdy_q, rdy_d, busy_q, busy_d;
    logic           tdir_q, tdir_d, ten_q, ten_d, tick, acc, want_dir;
    logic [PW-1:0]  pre_q, pre_d;
    logic [DW-1:0]  dt_q, dt_d;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
    logic [31:0]    wdt_q, wdt_d;
    logic           trip_q, trip_d;
`endif

    always_comb begin
        acc     = bus.cmd_valid && rdy_q;
        tick    = pre_q == PW'(RAMP_DIV - 1);
        pre_d   = tick ? '0 : pre_q + PW'(1);
        tdir_d  = acc ? bus.cmd_dir : tdir_q;
        tduty_d = acc ? bus.cmd_duty : tduty_q;
        ten_d   = acc ? bus.cmd_enable : ten_q;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
        wdt_d   = acc ? '0 : (trip_q ? wdt_q : wdt_q + 32'd1);
        trip_d  = !acc && (trip_q || wdt_q == WDT_TIMEOUT - 1);
        ten_d   = ten_d && !trip_d;
`endif
        // A disabled target means "stop in the present direction": never reverse.
        eff      = !ten_q ? '0 : (tduty_q < bus.period ? tduty_q : bus.period);
        want_dir = ten_q ? tdir_q : dir_q;
        goal     = state_q == BRAKE ? '0 : eff;
        up       = {1'b0, duty_q} + (W+1)'(RAMP_STEP);
        step     = duty_q < goal ? (up >= {1'b0, goal} ? goal : up[W-1:0])
                                 : (duty_q - goal <= W'(RAMP_STEP) ? goal : duty_q - W'(RAMP_STEP));
        state_d  = state_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        dt_d     = '0;
        case (state_q)
            IDLE: begin
                if (want_dir != dir_q)
                    state_d = duty_q != '0 ? BRAKE : DEADTIME;
                else if (duty_q != eff)
                    state_d = RAMP;
            end
            RAMP: begin
                if (want_dir != dir_q)
                    state_d = BRAKE;
                else if (duty_q == eff)
                    state_d = IDLE;
                else if (tick) begin
                    duty_d  = step;
                    state_d = step == eff ? IDLE : RAMP;
                end
            end
            BRAKE: begin
                if (want_dir == dir_q)
                    state_d = RAMP;
                else if (duty_q == '0)
                    state_d = DEADTIME;
                else if (tick)
                    duty_d = step;
            end
            DEADTIME: begin
                duty_d = '0;
                dt_d   = dt_q + DW'(1);
                if (dt_q == DW'(DEADTIME_CYCLES - 1)) begin
                    dir_d   = want_dir;
                    state_d = eff == '0 ? IDLE : RAMP;
                    dt_d    = '0;
                end
            end
        endcase
        on_d   = state_d != DEADTIME && !(duty_d == '0 && !ten_d);
        rdy_d  = state_d != DEADTIME;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            on_q    <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            tdir_q  <= 1'b0;
            tduty_q <= '0;
            ten_q   <= 1'b0;
            pre_q   <= '0;
            dt_q    <= '0;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
            wdt_q   <= '0;
            trip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            on_q    <= on_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            tdir_q  <= tdir_d;
            tduty_q <= tduty_d;
            ten_q   <= ten_d;
            pre_q   <= pre_d;
            dt_q    <= dt_d;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
            wdt_q   <= wdt_d;
            trip_q  <= trip_d;
`endif
        end
    end

    assign bus.cmd_ready = rdy_q;
    assign bus.pwm_dir   = dir_q;
    assign bus.pwm_on    = on_q;
    assign bus.pwm_duty  = duty_q;
    assign bus.busy      = busy_q;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
    assign bus.wdt_tripped = trip_q;
`endif
endmodule
